mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port instruction/data memory between the fetch stage and the load/store unit.
- Accepts one transaction at a time from either requester, drives the memory handshake and routes the response back to the owner.
- Applies a fetch-flush that drops stale instruction responses.
- Generates the fetch stall that holds the PC while the port is busy or owned by data traffic.

Parameters:
- AW, 32, address width.
- DW, 32, data width (byte enables are DW/8 bits).
- MAX_LS_RUN, 4, consecutive load/store grants allowed while IF_REQ is pending before fetch is forced to win.

Ports:
CLK  in  1  clock, rising edge
RES  in  1  asynchronous reset, active-high
IF_REQ  in  1  fetch request
IF_ADDR  in  AW  fetch address (PC)
IF_FLUSH  in  1  branch taken; discard in-flight/pending fetch
IF_GNT  out  1  fetch accepted this cycle
IF_RVALID  out  1  fetch data valid, 1-cycle pulse
IF_RDATA  out  DW  instruction word
IF_STALL  out  1  IF_REQ & ~IF_GNT
LS_REQ  in  1  load/store request
LS_WE  in  1  1 = store
LS_BE  in  DW/8  byte enables
LS_ADDR  in  AW  data address
LS_WDATA  in  DW  store data
LS_GNT  out  1  load/store accepted this cycle
LS_RVALID  out  1  load data / store ack, 1-cycle pulse
LS_RDATA  out  DW  load data
M_REQ  out  1  memory request, held until M_READY
M_WE  out  1  memory write enable
M_BE  out  DW/8  memory byte enables
M_ADDR  out  AW  memory address
M_WDATA  out  DW  memory write data
M_READY  in  1  memory completes access this cycle
M_RDATA  in  DW  read data, valid when M_READY

Behaviour:
- Reset (async, RES=1):
  - State goes to IDLE.
  - All outputs are 0: M_*, *_GNT, *_RVALID, *_RDATA.
  - Run counter is 0 and the drop flag is cleared.
  - Reset mid-transaction abandons it with no RVALID.
  - IF_STALL follows IF_REQ combinationally while in reset.
- States:
  - IDLE: port free. Grants are combinational this cycle.
  - BUSY_IF: fetch access outstanding.
  - BUSY_LS: load/store access outstanding.
- IDLE arbitration (at most one grant per cycle):
  - LS_REQ=1 and (IF_REQ=0 or run<MAX_LS_RUN) -> LS_GNT=1.
  - Otherwise, IF_REQ=1 and IF_FLUSH=0 -> IF_GNT=1.
  - IF_REQ with IF_FLUSH=1 is never granted that cycle.
- Run counter:
  - Increments (saturating at MAX_LS_RUN) on each LS grant.
  - Clears on each IF grant.
- On a grant edge:
  - Requester's address, WE, BE and WDATA are registered into M_*; fetch uses WE=0 and BE=all-ones.
  - M_REQ=1 from the next cycle; state becomes BUSY_IF or BUSY_LS.
- BUSY states:
  - M_* stay stable and no grants are issued.
  - Edge with M_REQ & M_READY: M_REQ drops, state returns to IDLE, M_RDATA is captured.
  - The owner's RVALID pulses for exactly the following cycle.
  - IDLE arbitration runs in that same cycle, giving 2 cycles per access minimum with zero-wait memory.
- Stores: LS_RVALID pulses as an ack; LS_RDATA holds its previous value.
- Loads and fetches:
  - *_RDATA is registered and holds until the next capture for that owner.
  - Fetch and load data never overwrite each other.
- Flush:
  - IF_FLUSH=1 while in BUSY_IF sets the drop flag.
  - IF_FLUSH=1 on the completing edge of BUSY_IF also sets the drop flag.
  - On completion with the drop flag set: IF_RVALID stays 0, IF_RDATA is unchanged, the flag clears.
  - The memory access always completes; it is never aborted.
  - IF_FLUSH has no effect in BUSY_LS or in IDLE apart from blocking IF_GNT.
- Simultaneous requests in IDLE: LS wins except when fairness forces IF. IF_REQ is never starved beyond MAX_LS_RUN data accesses.
- Address and data width: no arithmetic; widths pass through unchanged.

Test Plan:
- Reset:
  - Stimulus: assert RES asynchronously mid-BUSY_LS.
  - Required: all outputs go to 0 before the next edge; no LS_RVALID follows; IDLE after release.
- Zero-wait fetch:
  - Stimulus: IF_REQ=1, IF_ADDR=0x100, M_READY=1 tied, M_RDATA=0x00000013.
  - Required: IF_GNT in cycle 0; M_REQ/M_ADDR=0x100 in cycle 1; IF_RVALID with IF_RDATA=0x13 in cycle 2; next IF_GNT in cycle 2.
- Contention and fairness:
  - Stimulus: IF_REQ and LS_REQ held high with MAX_LS_RUN=4.
  - Required: grant order is LS,LS,LS,LS,IF,LS...; IF_STALL=1 in every non-IF-grant cycle.
- Store with wait states:
  - Stimulus: LS_WE=1, LS_ADDR=0x2004, LS_BE=0x3, LS_WDATA=0xBEEF; M_READY low for 3 cycles.
  - Required: M_* stable for 4 cycles; one LS_RVALID pulse; LS_RDATA unchanged.
- Flush in flight:
  - Stimulus: fetch granted at 0x200; IF_FLUSH pulses while BUSY_IF.
  - Required: no IF_RVALID and IF_RDATA unchanged; the next fetch at 0x300 returns normally.
- Flush at grant:
  - Stimulus: IF_REQ and IF_FLUSH both high in IDLE, LS_REQ=0.
  - Required: IF_GNT=0 and M_REQ stays 0; grant occurs the next cycle once IF_FLUSH is low.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port instruction/data memory between the fetch stage
//   and the load/store unit. One access is outstanding at a time. Responses
//   are routed back to whichever requester owns the access. A branch flush
//   drops a stale instruction response. Data traffic may win at most
//   MAX_LS_RUN consecutive grants while a fetch is waiting.
//
// Ports
//   CLK, RES          rising-edge clock, asynchronous active-high reset
//   IF_REQ/ADDR/FLUSH fetch request, PC and branch-taken flush
//   IF_GNT/STALL      fetch accepted this cycle / hold the PC
//   IF_RVALID/RDATA   registered instruction response (1-cycle pulse)
//   LS_REQ/WE/BE/ADDR/WDATA  load/store request
//   LS_GNT            load/store accepted this cycle
//   LS_RVALID/RDATA   load data or store ack (1-cycle pulse)
//   M_REQ/WE/BE/ADDR/WDATA   memory request, held stable until M_READY
//   M_READY/M_RDATA   memory completion and read data
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MAX_LS_RUN = 4
) (
  input  logic            CLK,
  input  logic            RES,
  input  logic            IF_REQ,
  input  logic [AW-1:0]   IF_ADDR,
  input  logic            IF_FLUSH,
  output logic            IF_GNT,
  output logic            IF_RVALID,
  output logic [DW-1:0]   IF_RDATA,
  output logic            IF_STALL,
  input  logic            LS_REQ,
  input  logic            LS_WE,
  input  logic [DW/8-1:0] LS_BE,
  input  logic [AW-1:0]   LS_ADDR,
  input  logic [DW-1:0]   LS_WDATA,
  output logic            LS_GNT,
  output logic            LS_RVALID,
  output logic [DW-1:0]   LS_RDATA,
  output logic            M_REQ,
  output logic            M_WE,
  output logic [DW/8-1:0] M_BE,
  output logic [AW-1:0]   M_ADDR,
  output logic [DW-1:0]   M_WDATA,
  input  logic            M_READY,
  input  logic [DW-1:0]   M_RDATA
);

  localparam int BW = DW / 8;
  localparam int RW = $clog2(MAX_LS_RUN + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(MAX_LS_RUN);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LS} state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   run_q, run_d;
  logic            drop_q, drop_d;
  logic            m_req_q, m_req_d;
  logic            m_we_q, m_we_d;
  logic [BW-1:0]   m_be_q, m_be_d;
  logic [AW-1:0]   m_addr_q, m_addr_d;
  logic [DW-1:0]   m_wdata_q, m_wdata_d;
  logic            if_rvalid_q, if_rvalid_d;
  logic [DW-1:0]   if_rdata_q, if_rdata_d;
  logic            ls_rvalid_q, ls_rvalid_d;
  logic [DW-1:0]   ls_rdata_q, ls_rdata_d;

  logic            idle;
  logic            ls_gnt;
  logic            if_gnt;

  // Grants are combinational from IDLE and forced low while in reset so
  // that IF_STALL simply mirrors IF_REQ during reset.
  assign idle   = (state_q == IDLE);
  assign ls_gnt = ~RES & idle & LS_REQ & (~IF_REQ | (run_q < RUN_MAX));
  assign if_gnt = ~RES & idle & ~ls_gnt & IF_REQ & ~IF_FLUSH;

  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    drop_d      = drop_q;
    m_req_d     = m_req_q;
    m_we_d      = m_we_q;
    m_be_d      = m_be_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    if_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    ls_rvalid_d = 1'b0;
    ls_rdata_d  = ls_rdata_q;

    case (state_q)
      IDLE: begin
        if (ls_gnt) begin
          state_d   = BUSY_LS;
          m_req_d   = 1'b1;
          m_we_d    = LS_WE;
          m_be_d    = LS_BE;
          m_addr_d  = LS_ADDR;
          m_wdata_d = LS_WDATA;
          run_d     = (run_q == RUN_MAX) ? run_q : run_q + RW'(1);
        end else if (if_gnt) begin
          state_d   = BUSY_IF;
          m_req_d   = 1'b1;
          m_we_d    = 1'b0;
          m_be_d    = '1;
          m_addr_d  = IF_ADDR;
          m_wdata_d = '0;
          run_d     = '0;
        end
      end
      BUSY_IF: begin
        // A flush anywhere in the access, including its completing cycle,
        // poisons the response; the memory access itself still finishes.
        if (IF_FLUSH) drop_d = 1'b1;
        if (m_req_q && M_READY) begin
          state_d = IDLE;
          m_req_d = 1'b0;
          drop_d  = 1'b0;
          if (!(drop_q || IF_FLUSH)) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = M_RDATA;
          end
        end
      end
      BUSY_LS: begin
        if (m_req_q && M_READY) begin
          state_d     = IDLE;
          m_req_d     = 1'b0;
          ls_rvalid_d = 1'b1;
          // Stores only acknowledge; the last load data is kept.
          if (!m_we_q) ls_rdata_d = M_RDATA;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_q     <= IDLE;
      run_q       <= '0;
      drop_q      <= 1'b0;
      m_req_q     <= 1'b0;
      m_we_q      <= 1'b0;
      m_be_q      <= '0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rvalid_q <= 1'b0;
      ls_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      drop_q      <= drop_d;
      m_req_q     <= m_req_d;
      m_we_q      <= m_we_d;
      m_be_q      <= m_be_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      ls_rvalid_q <= ls_rvalid_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

  assign IF_GNT    = if_gnt;
  assign LS_GNT    = ls_gnt;
  assign IF_STALL  = IF_REQ & ~if_gnt;
  assign IF_RVALID = if_rvalid_q;
  assign IF_RDATA  = if_rdata_q;
  assign LS_RVALID = ls_rvalid_q;
  assign LS_RDATA  = ls_rdata_q;
  assign M_REQ     = m_req_q;
  assign M_WE      = m_we_q;
  assign M_BE      = m_be_q;
  assign M_ADDR    = m_addr_q;
  assign M_WDATA   = m_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios followed by a
// randomized run checked against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int BW   = DW / 8;
  localparam int MAXR = 4;

  logic          clk = 1'b0;
  logic          res;
  logic          if_req, if_flush;
  logic [AW-1:0] if_addr;
  logic          if_gnt, if_rvalid, if_stall;
  logic [DW-1:0] if_rdata;
  logic          ls_req, ls_we;
  logic [BW-1:0] ls_be;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata;
  logic          ls_gnt, ls_rvalid;
  logic [DW-1:0] ls_rdata;
  logic          m_req, m_we;
  logic [BW-1:0] m_be;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_ready;
  logic [DW-1:0] m_rdata;

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_LS_RUN(MAXR)) dut (
    .CLK(clk), .RES(res),
    .IF_REQ(if_req), .IF_ADDR(if_addr), .IF_FLUSH(if_flush),
    .IF_GNT(if_gnt), .IF_RVALID(if_rvalid), .IF_RDATA(if_rdata), .IF_STALL(if_stall),
    .LS_REQ(ls_req), .LS_WE(ls_we), .LS_BE(ls_be), .LS_ADDR(ls_addr), .LS_WDATA(ls_wdata),
    .LS_GNT(ls_gnt), .LS_RVALID(ls_rvalid), .LS_RDATA(ls_rdata),
    .M_REQ(m_req), .M_WE(m_we), .M_BE(m_be), .M_ADDR(m_addr), .M_WDATA(m_wdata),
    .M_READY(m_ready), .M_RDATA(m_rdata)
  );

  always #5 clk = ~clk;

  // Reference memory contents for the randomized run.
  logic [DW-1:0] mem [logic [AW-1:0]];

  function automatic logic [DW-1:0] memrd(logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic apply_reset();
    res = 1'b1; if_req = 0; if_flush = 0; if_addr = '0;
    ls_req = 0; ls_we = 0; ls_be = '0; ls_addr = '0; ls_wdata = '0;
    m_ready = 0; m_rdata = '0;
    repeat (2) @(negedge clk);
    res = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    res = 1'b1; if_req = 1; ls_req = 1; #1;
    checks++; if (if_gnt !== 1'b0) begin failures++; $display("FAIL rst_if_gnt: got %b exp 0", if_gnt); end
    checks++; if (ls_gnt !== 1'b0) begin failures++; $display("FAIL rst_ls_gnt: got %b exp 0", ls_gnt); end
    checks++; if (if_stall !== 1'b1) begin failures++; $display("FAIL rst_stall: got %b exp 1", if_stall); end
    if_req = 0; ls_req = 0;
    @(negedge clk); res = 1'b0;
    // Start a load, then reset while it is outstanding.
    ls_req = 1; ls_we = 0; ls_addr = 32'h40; #1;
    checks++; if (ls_gnt !== 1'b1) begin failures++; $display("FAIL rst_pre_gnt: got %b exp 1", ls_gnt); end
    @(negedge clk); ls_req = 0; m_ready = 1; m_rdata = 32'hABCD0123;
    checks++; if (m_req !== 1'b1) begin failures++; $display("FAIL rst_pre_mreq: got %b exp 1", m_req); end
    #2 res = 1'b1; #1;
    checks++; if ({m_req, m_we, m_be, m_addr, m_wdata} !== '0) begin failures++; $display("FAIL rst_m_zero: got req=%b addr=%h", m_req, m_addr); end
    checks++; if ({if_rvalid, ls_rvalid, if_rdata, ls_rdata} !== '0) begin failures++; $display("FAIL rst_resp_zero: got ifd=%h lsd=%h", if_rdata, ls_rdata); end
    @(negedge clk); res = 1'b0;
    @(negedge clk);
    checks++; if (ls_rvalid !== 1'b0) begin failures++; $display("FAIL rst_no_rvalid: got %b exp 0", ls_rvalid); end
    checks++; if (m_req !== 1'b0) begin failures++; $display("FAIL rst_idle_mreq: got %b exp 0", m_req); end
    ls_req = 1; #1;
    checks++; if (ls_gnt !== 1'b1) begin failures++; $display("FAIL rst_idle_gnt: got %b exp 1", ls_gnt); end
    @(negedge clk); ls_req = 0;
    @(negedge clk);
  endtask

  task automatic test_zero_wait_fetch();
    apply_reset();
    if_req = 1; if_addr = 32'h100; m_ready = 1; m_rdata = 32'h13; #1;
    checks++; if (if_gnt !== 1'b1) begin failures++; $display("FAIL zw_gnt_c0: got %b exp 1", if_gnt); end
    checks++; if (if_stall !== 1'b0) begin failures++; $display("FAIL zw_stall_c0: got %b exp 0", if_stall); end
    @(negedge clk); if_addr = 32'h104;
    checks++; if ({m_req, m_we, m_be, m_addr} !== {1'b1, 1'b0, 4'hF, 32'h100}) begin failures++; $display("FAIL zw_m_c1: got req=%b we=%b be=%h addr=%h exp 1 0 f 100", m_req, m_we, m_be, m_addr); end
    checks++; if ({if_gnt, if_stall} !== 2'b01) begin failures++; $display("FAIL zw_busy_c1: got gnt=%b stall=%b exp 0 1", if_gnt, if_stall); end
    @(negedge clk); #1;
    checks++; if ({if_rvalid, if_rdata} !== {1'b1, 32'h13}) begin failures++; $display("FAIL zw_rvalid_c2: got v=%b d=%h exp 1 13", if_rvalid, if_rdata); end
    checks++; if ({if_gnt, m_req} !== 2'b10) begin failures++; $display("FAIL zw_gnt_c2: got gnt=%b mreq=%b exp 1 0", if_gnt, m_req); end
    @(negedge clk); if_req = 0;
    checks++; if ({m_req, m_addr, if_rvalid} !== {1'b1, 32'h104, 1'b0}) begin failures++; $display("FAIL zw_m_c3: got req=%b addr=%h v=%b", m_req, m_addr, if_rvalid); end
    @(negedge clk);
  endtask

  task automatic test_fairness();
    apply_reset();
    if_req = 1; if_addr = 32'h500; ls_req = 1; ls_we = 0; ls_addr = 32'h800; m_ready = 1; m_rdata = 32'h1;
    for (int c = 0; c < 24; c++) begin
      automatic bit gc = (c % 2) == 0;
      automatic bit exp_if = gc && ((c / 2) % 5 == 4);
      automatic bit exp_ls = gc && !exp_if;
      #1;
      checks++; if ({ls_gnt, if_gnt} !== {exp_ls, exp_if}) begin failures++; $display("FAIL fair_order c%0d: got ls=%b if=%b exp ls=%b if=%b", c, ls_gnt, if_gnt, exp_ls, exp_if); end
      checks++; if (if_stall !== !exp_if) begin failures++; $display("FAIL fair_stall c%0d: got %b exp %b", c, if_stall, !exp_if); end
      @(negedge clk);
    end
    if_req = 0; ls_req = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_store_wait();
    apply_reset();
    ls_req = 1; ls_we = 0; ls_addr = 32'h10; m_ready = 1; m_rdata = 32'hCAFE1234; #1;
    checks++; if (ls_gnt !== 1'b1) begin failures++; $display("FAIL st_load_gnt: got %b exp 1", ls_gnt); end
    @(negedge clk); ls_req = 0;
    @(negedge clk);
    checks++; if ({ls_rvalid, ls_rdata} !== {1'b1, 32'hCAFE1234}) begin failures++; $display("FAIL st_load_data: got v=%b d=%h exp 1 cafe1234", ls_rvalid, ls_rdata); end
    ls_req = 1; ls_we = 1; ls_addr = 32'h2004; ls_be = 4'h3; ls_wdata = 32'hBEEF; m_ready = 0; m_rdata = 32'hDEAD0000; #1;
    checks++; if (ls_gnt !== 1'b1) begin failures++; $display("FAIL st_gnt: got %b exp 1", ls_gnt); end
    @(negedge clk); ls_req = 0; ls_we = 0; ls_addr = 32'h0; ls_be = 4'h0; ls_wdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      checks++; if ({m_req, m_we, m_be, m_addr, m_wdata} !== {1'b1, 1'b1, 4'h3, 32'h2004, 32'hBEEF}) begin failures++; $display("FAIL st_m_stable c%0d: got req=%b we=%b be=%h addr=%h wd=%h", i, m_req, m_we, m_be, m_addr, m_wdata); end
      checks++; if (ls_rvalid !== 1'b0) begin failures++; $display("FAIL st_early_rvalid c%0d: got %b exp 0", i, ls_rvalid); end
      m_ready = (i == 3);
      @(negedge clk);
    end
    m_ready = 0;
    checks++; if ({ls_rvalid, ls_rdata, m_req} !== {1'b1, 32'hCAFE1234, 1'b0}) begin failures++; $display("FAIL st_ack: got v=%b d=%h mreq=%b exp 1 cafe1234 0", ls_rvalid, ls_rdata, m_req); end
    @(negedge clk);
    checks++; if (ls_rvalid !== 1'b0) begin failures++; $display("FAIL st_single_pulse: got %b exp 0", ls_rvalid); end
  endtask

  task automatic test_flush_in_flight();
    apply_reset();
    if_req = 1; if_addr = 32'h80; m_ready = 1; m_rdata = 32'h11111111;
    @(negedge clk); if_req = 0;
    @(negedge clk);
    checks++; if ({if_rvalid, if_rdata} !== {1'b1, 32'h11111111}) begin failures++; $display("FAIL fl_prime: got v=%b d=%h", if_rvalid, if_rdata); end
    if_req = 1; if_addr = 32'h200; m_ready = 0; #1;
    checks++; if (if_gnt !== 1'b1) begin failures++; $display("FAIL fl_gnt200: got %b exp 1", if_gnt); end
    @(negedge clk); if_req = 0; if_flush = 1;
    checks++; if (m_addr !== 32'h200) begin failures++; $display("FAIL fl_addr200: got %h exp 200", m_addr); end
    @(negedge clk); if_flush = 0; m_ready = 1; m_rdata = 32'h22222222;
    @(negedge clk);
    checks++; if ({if_rvalid, if_rdata, m_req} !== {1'b0, 32'h11111111, 1'b0}) begin failures++; $display("FAIL fl_dropped: got v=%b d=%h mreq=%b exp 0 11111111 0", if_rvalid, if_rdata, m_req); end
    if_req = 1; if_addr = 32'h300; m_rdata = 32'h33333333; #1;
    checks++; if (if_gnt !== 1'b1) begin failures++; $display("FAIL fl_gnt300: got %b exp 1", if_gnt); end
    @(negedge clk); if_req = 0;
    @(negedge clk);
    checks++; if ({if_rvalid, if_rdata} !== {1'b1, 32'h33333333}) begin failures++; $display("FAIL fl_resume: got v=%b d=%h exp 1 33333333", if_rvalid, if_rdata); end
    // Flush arriving on the completing cycle also drops the response.
    if_req = 1; if_addr = 32'h400; m_rdata = 32'h44444444;
    @(negedge clk); if_req = 0; if_flush = 1;
    @(negedge clk); if_flush = 0;
    checks++; if ({if_rvalid, if_rdata} !== {1'b0, 32'h33333333}) begin failures++; $display("FAIL fl_edge_drop: got v=%b d=%h exp 0 33333333", if_rvalid, if_rdata); end
  endtask

  task automatic test_flush_at_grant();
    apply_reset();
    if_req = 1; if_flush = 1; if_addr = 32'h600; m_ready = 1; #1;
    checks++; if ({if_gnt, if_stall} !== 2'b01) begin failures++; $display("FAIL fg_blocked: got gnt=%b stall=%b exp 0 1", if_gnt, if_stall); end
    @(negedge clk);
    checks++; if (m_req !== 1'b0) begin failures++; $display("FAIL fg_no_mreq: got %b exp 0", m_req); end
    if_flush = 0; #1;
    checks++; if (if_gnt !== 1'b1) begin failures++; $display("FAIL fg_gnt_after: got %b exp 1", if_gnt); end
    @(negedge clk); if_req = 0;
    checks++; if ({m_req, m_addr} !== {1'b1, 32'h600}) begin failures++; $display("FAIL fg_mreq: got req=%b addr=%h", m_req, m_addr); end
    @(negedge clk);
  endtask

  task automatic test_random();
    bit out_busy = 0, out_is_if = 0, drop = 0;
    bit exp_if_rv = 0, exp_ls_rv = 0, exp_if_g, exp_ls_g;
    int lsrun = 0;
    logic [AW-1:0] t_addr = '0;
    logic          t_we = 0;
    logic [BW-1:0] t_be = '0;
    logic [DW-1:0] t_wdata = '0, exp_if_rdata = '0, exp_ls_rdata = '0, w;
    apply_reset();
    mem.delete();
    for (int c = 0; c < 3000; c++) begin
      checks++; if ({if_rvalid, if_rdata} !== {exp_if_rv, exp_if_rdata}) begin failures++; $display("FAIL rnd_if_resp c%0d: got v=%b d=%h exp v=%b d=%h", c, if_rvalid, if_rdata, exp_if_rv, exp_if_rdata); end
      checks++; if ({ls_rvalid, ls_rdata} !== {exp_ls_rv, exp_ls_rdata}) begin failures++; $display("FAIL rnd_ls_resp c%0d: got v=%b d=%h exp v=%b d=%h", c, ls_rvalid, ls_rdata, exp_ls_rv, exp_ls_rdata); end
      checks++; if (m_req !== out_busy) begin failures++; $display("FAIL rnd_mreq c%0d: got %b exp %b", c, m_req, out_busy); end
      if (out_busy) begin
        checks++; if ({m_addr, m_we, m_be} !== {t_addr, t_we, t_be} || (!out_is_if && m_wdata !== t_wdata)) begin failures++; $display("FAIL rnd_mbus c%0d: got a=%h we=%b be=%h wd=%h exp a=%h we=%b be=%h wd=%h", c, m_addr, m_we, m_be, m_wdata, t_addr, t_we, t_be, t_wdata); end
      end
      if_req   = ($urandom_range(0, 3) != 0);
      if_addr  = AW'($urandom_range(0, 15) * 4);
      if_flush = ($urandom_range(0, 7) == 0);
      ls_req   = ($urandom_range(0, 1) == 1);
      ls_we    = ($urandom_range(0, 1) == 1);
      ls_be    = BW'($urandom_range(0, 15));
      ls_addr  = AW'($urandom_range(0, 15) * 4);
      ls_wdata = $urandom;
      m_ready  = ($urandom_range(0, 2) != 0);
      m_rdata  = (out_busy && m_ready) ? memrd(t_addr) : $urandom;
      #1;
      exp_ls_g = !out_busy && ls_req && (!if_req || lsrun < MAXR);
      exp_if_g = !out_busy && !exp_ls_g && if_req && !if_flush;
      checks++; if ({ls_gnt, if_gnt, if_stall} !== {exp_ls_g, exp_if_g, if_req && !exp_if_g}) begin failures++; $display("FAIL rnd_gnt c%0d: got ls=%b if=%b st=%b exp ls=%b if=%b run=%0d", c, ls_gnt, if_gnt, if_stall, exp_ls_g, exp_if_g, lsrun); end
      exp_if_rv = 0; exp_ls_rv = 0;
      if (out_busy) begin
        if (out_is_if && if_flush) drop = 1;
        if (m_ready) begin
          out_busy = 0;
          if (out_is_if) begin
            if (!drop) begin exp_if_rv = 1; exp_if_rdata = m_rdata; end
            drop = 0;
          end else begin
            exp_ls_rv = 1;
            if (t_we) begin
              w = memrd(t_addr);
              for (int b = 0; b < BW; b++) if (t_be[b]) w[8*b +: 8] = t_wdata[8*b +: 8];
              mem[t_addr] = w;
            end else exp_ls_rdata = m_rdata;
          end
        end
      end else if (exp_ls_g) begin
        out_busy = 1; out_is_if = 0;
        t_addr = ls_addr; t_we = ls_we; t_be = ls_be; t_wdata = ls_wdata;
        if (lsrun < MAXR) lsrun++;
      end else if (exp_if_g) begin
        out_busy = 1; out_is_if = 1;
        t_addr = if_addr; t_we = 0; t_be = '1;
        lsrun = 0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait_fetch();
    test_fairness();
    test_store_wait();
    test_flush_in_flight();
    test_flush_at_grant();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
